banner_sequencer: RTL and testbench

//  Controller for the rotating LED banner on the 4-digit 7-segment display. Holds an
//  N-digit BCD message, accepts a new message over a valid/ready load port, advances a

---
 rtl/banner_sequencer_pkg.sv | 23 ++
 rtl/lcd7_segment_decoder.sv | 24 ++
 rtl/banner_sequencer.sv | 160 ++++++++++++++++
 tb/tb_banner_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/banner_sequencer_pkg.sv
// Shared types and constants for the rotating 7-segment banner controller.
package banner_sequencer_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  localparam logic [6:0] BLANK_SEG = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  // Message index shown on window digit k (3 = leftmost): (pos + 3 - k) mod n.
  // pos + 3 - k never exceeds 2n-1, so one conditional subtract suffices.
  function automatic logic [3:0] win_index(input logic [3:0] pos,
                                           input logic [1:0] k,
                                           input logic [4:0] n);
    logic [4:0] s;
    s = {1'b0, pos} + 5'd3 - {3'b000, k};
    if (s >= n) s = s - n;
    return s[3:0];
  endfunction

endpackage

// File: rtl/lcd7_segment_decoder.sv
// BCD to 7-segment decoder, active-high {g,f,e,d,c,b,a}; codes 10..15 give all-off.
module lcd7_segment_decoder (
  input  logic [3:0] x,
  output logic [6:0] y
);

  always_comb begin
    y = 7'h00;
    case (x)
      4'd0: y = 7'h3F;
      4'd1: y = 7'h06;
      4'd2: y = 7'h5B;
      4'd3: y = 7'h4F;
      4'd4: y = 7'h66;
      4'd5: y = 7'h6D;
      4'd6: y = 7'h7D;
      4'd7: y = 7'h07;
      4'd8: y = 7'h7F;
      4'd9: y = 7'h6F;
      default: y = 7'h00;
    endcase
  end

endmodule

// File: rtl/banner_sequencer.sv
// Rotating BCD banner: message store, load handshake, rotation pointer and 4-digit
// multiplexed 7-segment drive with registered, active-low outputs.
module banner_sequencer
  import banner_sequencer_pkg::*;
#(
  parameter int N_DIGITS = 10,
  parameter int ROT_DIV  = 25_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic       dir,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [3:0] load_digit,
  output logic       load_ready,
  output logic [3:0] pos,
  output logic [6:0] segment,
  output logic [3:0] anode,
  output state_e     fsm_state
);

  localparam int RW = (ROT_DIV > 1) ? $clog2(ROT_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [RW-1:0] ROT_LAST  = RW'(ROT_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [3:0]    N_LAST    = 4'(N_DIGITS - 1);
  localparam logic [4:0]    N5        = 5'(N_DIGITS);

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [3:0]      pos_q, pos_d;
  logic [RW-1:0]   rot_q, rot_d;
  logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [1:0]      scan_q, scan_d;
  logic [3:0]      anode_q, anode_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      msg_q [N_DIGITS];
  logic            tick;
  logic            wr_en;
  logic [3:0]      win;
  logic [3:0]      digit;
  logic [6:0]      dec_y;

  // Load handshake: a digit transfers on every rising edge where load_valid and
  // load_ready are both 1; load_ready is 1 exactly while in LOAD, independent of load_valid.
  assign load_ready = (state_q == ST_LOAD);
  assign wr_en      = load_ready && load_valid;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pos_d   = pos_q;
    rot_d   = rot_q;
    tick    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (en) begin
          if (rot_q == ROT_LAST) begin
            rot_d = '0;
            tick  = 1'b1;
          end else begin
            rot_d = rot_q + 1'b1;
          end
        end
        // A load request takes priority over a coincident rotation step.
        if (load_start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end else if (tick) begin
          if (dir) pos_d = (pos_q == 4'd0) ? N_LAST : pos_q - 4'd1;
          else     pos_d = (pos_q == N_LAST) ? 4'd0 : pos_q + 4'd1;
        end
      end
      ST_LOAD: begin
        if (load_valid) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == N_LAST) begin
            state_d = ST_RUN;
            idx_d   = '0;
            pos_d   = '0;
            rot_d   = '0;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    scan_d     = scan_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_d     = scan_q + 2'd1;
    end
  end

  always_comb begin
    win   = win_index(pos_q, scan_q, N5);
    digit = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (win == 4'(i)) digit = msg_q[i];
    end
  end

  lcd7_segment_decoder u_dec (
    .x (digit),
    .y (dec_y)
  );

  always_comb begin
    anode_d = ~(4'b0001 << scan_q);
    seg_d   = ~dec_y;
    if (digit > 4'd9) seg_d = BLANK_SEG;
    if (state_q == ST_LOAD) begin
      anode_d = ANODE_OFF;
      seg_d   = BLANK_SEG;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      idx_q      <= '0;
      pos_q      <= '0;
      rot_q      <= '0;
      scan_cnt_q <= '0;
      scan_q     <= '0;
      anode_q    <= ANODE_OFF;
      seg_q      <= BLANK_SEG;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pos_q      <= pos_d;
      rot_q      <= rot_d;
      scan_cnt_q <= scan_cnt_d;
      scan_q     <= scan_d;
      anode_q    <= anode_d;
      seg_q      <= seg_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_DIGITS; i++) msg_q[i] <= 4'(i % 10);
    end else begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (wr_en && idx_q == 4'(i)) msg_q[i] <= load_digit;
      end
    end
  end

  assign pos       = pos_q;
  assign segment   = seg_q;
  assign anode     = anode_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_banner_sequencer.sv
// Directed bench for banner_sequencer with small prescalers (ROT_DIV=4, SCAN_DIV=2).
module tb_banner_sequencer;
  import banner_sequencer_pkg::*;

  logic       clock;
  logic       reset;
  logic       en;
  logic       dir;
  logic       load_start;
  logic       load_valid;
  logic [3:0] load_digit;
  logic       load_ready;
  logic [3:0] pos;
  logic [6:0] segment;
  logic [3:0] anode;
  state_e     fsm_state;

  int checks   = 0;
  int failures = 0;

  banner_sequencer #(
    .N_DIGITS (10),
    .ROT_DIV  (4),
    .SCAN_DIV (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .en         (en),
    .dir        (dir),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_digit (load_digit),
    .load_ready (load_ready),
    .pos        (pos),
    .segment    (segment),
    .anode      (anode),
    .fsm_state  (fsm_state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Wait (bounded) until window digit k is lit, then compare its segments.
  task automatic check_digit(input string tag, input int k, input logic [6:0] exp_seg);
    logic [3:0] target;
    target = ~(4'b0001 << k);
    step();
    for (int i = 0; i < 12; i++) begin
      if (anode == target) break;
      step();
    end
    chk({tag, "_anode"}, 32'(anode), 32'(target));
    chk({tag, "_seg"}, 32'(segment), 32'(exp_seg));
  endtask

  initial begin
    int k;
    logic [3:0] exp_an;
    int gaps [10] = '{0, 1, 2, 3, 0, 2, 1, 3, 0, 1};
    int alt  [10] = '{15, 1, 2, 3, 4, 5, 6, 7, 8, 9};

    reset = 1'b0; en = 1'b0; dir = 1'b0;
    load_start = 1'b0; load_valid = 1'b0; load_digit = 4'd0;
    repeat (3) step();
    chk("rst_anode", 32'(anode), 32'h0000000F);
    chk("rst_seg", 32'(segment), 32'h0000007F);
    chk("rst_pos", 32'(pos), 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'(ST_RUN));

    // 1: paused rotation, display scans digits 0..3 every 2 clocks
    reset = 1'b1;
    for (int p = 1; p <= 40; p++) begin
      step();
      k = ((p - 1) / 2) % 4;
      exp_an = ~(4'b0001 << k);
      chk("t1_anode", 32'(anode), 32'(exp_an));
      chk("t1_seg", 32'(segment), 32'(enc(3 - k)));
      chk("t1_pos", 32'(pos), 32'd0);
    end

    // 2: rotate left, one tick per 4 clocks, wrap 9->0 on the 10th tick
    en = 1'b1; dir = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      step();
      chk("t2_pos", 32'(pos), 32'((c / 4) % 10));
    end
    en = 1'b0;

    // 3: rotate right from 0 wraps to 9
    dir = 1'b1; en = 1'b1;
    repeat (3) step();
    chk("t3_pos_pre", 32'(pos), 32'd0);
    step();
    en = 1'b0;
    chk("t3_pos", 32'(pos), 32'd9);
    check_digit("t3_d3", 3, enc(9));
    check_digit("t3_d0", 0, enc(2));

    // 4: pause mid-count preserves prescaler phase
    dir = 1'b0; en = 1'b1;
    repeat (2) step();
    en = 1'b0;
    repeat (3) step();
    chk("t4_pos_paused", 32'(pos), 32'd9);
    en = 1'b1;
    step();
    chk("t4_pos_1", 32'(pos), 32'd9);
    step();
    chk("t4_pos_2", 32'(pos), 32'd0);
    en = 1'b0;

    // 4b: dir changed between ticks only matters at the tick
    en = 1'b1; dir = 1'b0;
    repeat (2) step();
    chk("t4b_pos_mid", 32'(pos), 32'd0);
    dir = 1'b1;
    repeat (2) step();
    chk("t4b_pos", 32'(pos), 32'd9);
    en = 1'b0; dir = 1'b0;

    // 5: load 9..0 with gaps; a stray load_start inside LOAD is ignored
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("t5_state", 32'(fsm_state), 32'(ST_LOAD));
    chk("t5_ready", 32'(load_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        if (i == 2 && g == 0) load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("t5_gap_ready", 32'(load_ready), 32'd1);
        chk("t5_gap_anode", 32'(anode), 32'h0000000F);
      end
      load_valid = 1'b1;
      load_digit = 4'(9 - i);
      chk("t5_hs_ready", 32'(load_ready), 32'd1);
      step();
      load_valid = 1'b0;
    end
    chk("t5_state_done", 32'(fsm_state), 32'(ST_RUN));
    chk("t5_ready_done", 32'(load_ready), 32'd0);
    chk("t5_pos_done", 32'(pos), 32'd0);
    check_digit("t5_d3", 3, enc(9));
    check_digit("t5_d2", 2, enc(8));
    check_digit("t5_d0", 0, enc(6));

    // 5b: load_start coinciding with a tick wins; out-of-range digit blanks
    en = 1'b1;
    repeat (3) step();
    load_start = 1'b1;
    step();
    load_start = 1'b0; en = 1'b0;
    chk("t5b_state", 32'(fsm_state), 32'(ST_LOAD));
    chk("t5b_pos", 32'(pos), 32'd0);
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1;
      load_digit = 4'(alt[i]);
      step();
    end
    load_valid = 1'b0;
    chk("t5b_state_done", 32'(fsm_state), 32'(ST_RUN));
    check_digit("t5b_d3", 3, 7'h7F);
    check_digit("t5b_d2", 2, enc(1));
    check_digit("t5b_d0", 0, enc(3));

    // 6: reset in the middle of a load discards the partial message
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_digit = 4'd7;
      step();
    end
    load_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("t6_anode", 32'(anode), 32'h0000000F);
    chk("t6_seg", 32'(segment), 32'h0000007F);
    chk("t6_ready", 32'(load_ready), 32'd0);
    chk("t6_state", 32'(fsm_state), 32'(ST_RUN));
    @(negedge clock);
    reset = 1'b1;
    step();
    chk("t6_ready_rel", 32'(load_ready), 32'd0);
    chk("t6_state_rel", 32'(fsm_state), 32'(ST_RUN));
    chk("t6_pos_rel", 32'(pos), 32'd0);
    check_digit("t6_d3", 3, enc(0));
    check_digit("t6_d1", 1, enc(2));
    check_digit("t6_d0", 0, enc(3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
